// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO serial configuration sequencer.
package gpio_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LOAD,
    ST_DONE
  } gpio_cfg_state_e;

  localparam int REQ_MGMT  = 0;
  localparam int REQ_HKSPI = 1;

  // Bit p gives the serial_clock / serial_resetn level during LOAD phase p.
  localparam logic [3:0] LOAD_CLK  = 4'b0111;
  localparam logic [3:0] LOAD_RSTN = 4'b1101;

endpackage

// File: rtl/gpio_cfg_phase_timer.sv
// Down-counter timing one serial phase of CLK_DIV+1 clk cycles; reloads itself at phase end.
module gpio_cfg_phase_timer #(
  parameter int CLK_DIV = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  output logic phase_end
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= RELOAD;
    end else if (load || cnt == 8'd0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

  assign phase_end = (cnt == 8'd0);

endmodule

// File: rtl/gpio_cfg_sequencer.sv
// Arbitrates the GPIO configuration chain between mgmt and hkspi, shifts per-pad
// control words out MSB-first (last pad first) and finishes with the load strobe.
module gpio_cfg_sequencer
  import gpio_cfg_pkg::*;
#(
  parameter int NUM_PADS  = 38,
  parameter int CTRL_BITS = 13,
  parameter int CLK_DIV   = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [1:0]           req,
  input  logic                 abort,
  output logic [1:0]           gnt,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_rd,
  output logic [5:0]           cfg_idx,
  input  logic [CTRL_BITS-1:0] cfg_word,
  output logic                 serial_clock,
  output logic                 serial_resetn,
  output logic                 serial_data_out,
  output gpio_cfg_state_e      dbg_state
);

  localparam logic [5:0] PAD_LAST = 6'(NUM_PADS - 1);
  localparam logic [3:0] BIT_LAST = 4'(CTRL_BITS - 1);

  // Handshakes: req is a level sampled only in IDLE; gnt stays one-hot until the
  // cycle after DONE. cfg_rd is a one-cycle strobe and the owner must present
  // cfg_word for cfg_idx on the following cycle, when it is captured unconditionally.
  gpio_cfg_state_e       state;
  logic [CTRL_BITS-1:0]  staging;
  logic [5:0]            pad_cnt;
  logic [3:0]            bit_cnt;
  logic [1:0]            load_phase;
  logic [1:0]            load_phase_nxt;
  logic                  last_hk;
  logic [1:0]            arb_gnt;
  logic                  timer_load;
  logic                  phase_end;

  gpio_cfg_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .load      (timer_load),
    .phase_end (phase_end)
  );

  assign timer_load      = (state != ST_SHIFT_LO) && (state != ST_SHIFT_HI) && (state != ST_LOAD);
  assign load_phase_nxt  = load_phase + 2'd1;
  assign serial_data_out = staging[CTRL_BITS-1];
  assign dbg_state       = state;

  // Round-robin tie break: whoever was not served last wins.
  always_comb begin
    arb_gnt = req;
    if (req[REQ_MGMT] && req[REQ_HKSPI]) begin
      arb_gnt = 2'b00;
      if (last_hk) arb_gnt[REQ_MGMT]  = 1'b1;
      else         arb_gnt[REQ_HKSPI] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      gnt           <= 2'b00;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_rd        <= 1'b0;
      cfg_idx       <= PAD_LAST;
      serial_clock  <= 1'b0;
      serial_resetn <= 1'b0;
      staging       <= '0;
      pad_cnt       <= PAD_LAST;
      bit_cnt       <= 4'd0;
      load_phase    <= 2'd0;
      last_hk       <= 1'b1;
    end else begin
      done   <= 1'b0;
      cfg_rd <= 1'b0;
      if (abort && state != ST_IDLE) begin
        // Abandon without touching the pad latches; the arbiter pointer is kept.
        state         <= ST_IDLE;
        gnt           <= 2'b00;
        busy          <= 1'b0;
        serial_clock  <= 1'b0;
        serial_resetn <= 1'b1;
        staging       <= '0;
        pad_cnt       <= PAD_LAST;
      end else begin
        case (state)
          ST_IDLE: begin
            serial_clock  <= 1'b0;
            serial_resetn <= 1'b1;
            pad_cnt       <= PAD_LAST;
            if (|req) begin
              gnt     <= arb_gnt;
              busy    <= 1'b1;
              cfg_rd  <= 1'b1;
              cfg_idx <= PAD_LAST;
              state   <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            state <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            staging <= cfg_word;
            bit_cnt <= 4'd0;
            state   <= ST_SHIFT_LO;
          end
          ST_SHIFT_LO: begin
            if (phase_end) begin
              serial_clock <= 1'b1;
              state        <= ST_SHIFT_HI;
            end
          end
          ST_SHIFT_HI: begin
            if (phase_end) begin
              staging <= staging << 1;
              if (bit_cnt != BIT_LAST) begin
                bit_cnt      <= bit_cnt + 4'd1;
                serial_clock <= 1'b0;
                state        <= ST_SHIFT_LO;
              end else if (pad_cnt != 6'd0) begin
                pad_cnt      <= pad_cnt - 6'd1;
                cfg_idx      <= pad_cnt - 6'd1;
                cfg_rd       <= 1'b1;
                serial_clock <= 1'b0;
                state        <= ST_FETCH;
              end else begin
                load_phase    <= 2'd0;
                serial_clock  <= LOAD_CLK[0];
                serial_resetn <= LOAD_RSTN[0];
                state         <= ST_LOAD;
              end
            end
          end
          ST_LOAD: begin
            if (phase_end) begin
              if (load_phase == 2'd3) begin
                serial_clock  <= 1'b0;
                serial_resetn <= 1'b1;
                done          <= 1'b1;
                last_hk       <= gnt[REQ_HKSPI];
                state         <= ST_DONE;
              end else begin
                load_phase    <= load_phase_nxt;
                serial_clock  <= LOAD_CLK[load_phase_nxt];
                serial_resetn <= LOAD_RSTN[load_phase_nxt];
              end
            end
          end
          ST_DONE: begin
            gnt   <= 2'b00;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_cfg_sequencer.sv
// Directed bench for gpio_cfg_sequencer: small chain (2x4, div 0 and 2) plus the default 38x13 chain.
module tb_gpio_cfg_sequencer;
  import gpio_cfg_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [1:0] a_req, a_gnt, b_req, b_gnt, c_req, c_gnt;
  logic a_abort, b_abort, c_abort;
  logic a_busy, a_done, a_cfg_rd, a_sclk, a_srstn, a_sdo;
  logic b_busy, b_done, b_cfg_rd, b_sclk, b_srstn, b_sdo;
  logic c_busy, c_done, c_cfg_rd, c_sclk, c_srstn, c_sdo;
  logic [5:0] a_cfg_idx, b_cfg_idx, c_cfg_idx;
  logic [3:0] a_cfg_word, b_cfg_word;
  logic [12:0] c_cfg_word;
  gpio_cfg_state_e a_st, b_st, c_st;

  // Register files: pad1 = 0xA, pad0 = 0x3 for the small chains.
  assign a_cfg_word = (a_cfg_idx == 6'd1) ? 4'hA : 4'h3;
  assign b_cfg_word = (b_cfg_idx == 6'd1) ? 4'hA : 4'h3;
  assign c_cfg_word = {7'd0, c_cfg_idx} ^ 13'h1555;

  gpio_cfg_sequencer #(.NUM_PADS(2), .CTRL_BITS(4), .CLK_DIV(0)) dut_a (
    .clk(clk), .resetn(resetn), .req(a_req), .abort(a_abort), .gnt(a_gnt),
    .busy(a_busy), .done(a_done), .cfg_rd(a_cfg_rd), .cfg_idx(a_cfg_idx),
    .cfg_word(a_cfg_word), .serial_clock(a_sclk), .serial_resetn(a_srstn),
    .serial_data_out(a_sdo), .dbg_state(a_st));

  gpio_cfg_sequencer #(.NUM_PADS(2), .CTRL_BITS(4), .CLK_DIV(2)) dut_b (
    .clk(clk), .resetn(resetn), .req(b_req), .abort(b_abort), .gnt(b_gnt),
    .busy(b_busy), .done(b_done), .cfg_rd(b_cfg_rd), .cfg_idx(b_cfg_idx),
    .cfg_word(b_cfg_word), .serial_clock(b_sclk), .serial_resetn(b_srstn),
    .serial_data_out(b_sdo), .dbg_state(b_st));

  gpio_cfg_sequencer dut_c (
    .clk(clk), .resetn(resetn), .req(c_req), .abort(c_abort), .gnt(c_gnt),
    .busy(c_busy), .done(c_done), .cfg_rd(c_cfg_rd), .cfg_idx(c_cfg_idx),
    .cfg_word(c_cfg_word), .serial_clock(c_sclk), .serial_resetn(c_srstn),
    .serial_data_out(c_sdo), .dbg_state(c_st));

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- scoreboard / monitors ----------------
  logic [0:0] exp_q[$];
  logic [5:0] a_idx_q[$];
  logic       a_mon_en = 1'b0;
  int a_rl = 0, a_dc = 0, a_both = 0, c_edges = 0;

  always @(posedge a_sclk) begin
    if (a_mon_en) begin
      if (exp_q.size() == 0) check("a_sdo_extra_edge", 32'd1, 32'd0);
      else check("a_sdo_bit", 32'(a_sdo), 32'(exp_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (a_mon_en && a_cfg_rd) a_idx_q.push_back(a_cfg_idx);
    if (resetn && !a_srstn) a_rl++;
    if (resetn && a_done) a_dc++;
    if (a_gnt == 2'b11) a_both++;
  end

  always @(posedge c_sclk) c_edges++;

  // ---------------- driver tasks ----------------
  task automatic wait_a_done(input string tag, output int cyc);
    cyc = 1;
    while (!a_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    if (!a_done) check(tag, 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, shi, dones, run, n_runs, lows;
    logic [1:0] prev_gnt;
    logic [1:0] g_log[$];
    logic [7:0] pat;
    gpio_cfg_state_e prev_st;
    logic prev_sc, prev_sr;

    a_req = 2'b00; b_req = 2'b00; c_req = 2'b00;
    a_abort = 1'b0; b_abort = 1'b0; c_abort = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_gnt", 32'(a_gnt), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_cfg_rd", 32'(a_cfg_rd), 32'd0);
    check("rst_cfg_idx", 32'(a_cfg_idx), 32'd1);
    check("rst_cfg_idx_c", 32'(c_cfg_idx), 32'd37);
    check("rst_sclk", 32'(a_sclk), 32'd0);
    check("rst_srstn", 32'(a_srstn), 32'd0);
    check("rst_sdo", 32'(a_sdo), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("srstn_after_release", 32'(a_srstn), 32'd1);

    // Basic transfer on 2x4 chain, mgmt
    pat = 8'b10100011;
    for (int i = 7; i >= 0; i--) exp_q.push_back(pat[i]);
    a_rl = 0; a_dc = 0; a_mon_en = 1'b1;
    a_req = 2'b01;
    @(negedge clk);
    a_req = 2'b00;
    check("a_gnt_latency", 32'(a_gnt), 32'd1);
    check("a_busy_latency", 32'(a_busy), 32'd1);
    check("a_cfg_rd_latency", 32'(a_cfg_rd), 32'd1);
    wait_a_done("a_done_timeout", cyc);
    check("a_done_cycles", 32'(cyc), 32'd25);
    @(negedge clk);
    a_mon_en = 1'b0;
    check("a_idle_busy", 32'(a_busy), 32'd0);
    check("a_idle_gnt", 32'(a_gnt), 32'd0);
    check("a_sdo_remaining", 32'(exp_q.size()), 32'd0);
    check("a_idx_count", 32'(a_idx_q.size()), 32'd2);
    if (a_idx_q.size() >= 2) begin
      check("a_idx_first", 32'(a_idx_q[0]), 32'd1);
      check("a_idx_second", 32'(a_idx_q[1]), 32'd0);
    end
    check("a_load_low_cycles", 32'(a_rl), 32'd1);
    check("a_done_pulses", 32'(a_dc), 32'd1);

    // Reset in the middle of SHIFT_LO (hkspi transfer)
    a_req = 2'b10;
    cyc = 0;
    while (a_st != ST_SHIFT_LO && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("a_reach_shift_lo", 32'(a_st), 32'(ST_SHIFT_LO));
    check("a_sdo_pre_reset", 32'(a_sdo), 32'd1);
    resetn = 1'b0;
    #1;
    check("midrst_gnt", 32'(a_gnt), 32'd0);
    check("midrst_busy", 32'(a_busy), 32'd0);
    check("midrst_srstn", 32'(a_srstn), 32'd0);
    check("midrst_sclk", 32'(a_sclk), 32'd0);
    check("midrst_sdo", 32'(a_sdo), 32'd0);
    check("midrst_cfg_idx", 32'(a_cfg_idx), 32'd1);
    @(negedge clk);
    a_req = 2'b11;
    resetn = 1'b1;
    @(negedge clk);
    check("tie_after_reset", 32'(a_gnt), 32'd1);

    // req=11 held across three transfers
    g_log.delete();
    prev_gnt = 2'b00; dones = 0; cyc = 0; a_both = 0;
    while (dones < 3 && cyc < 300) begin
      if (a_gnt != 2'b00 && prev_gnt == 2'b00) begin
        g_log.push_back(a_gnt);
        if (g_log.size() == 3) a_req = 2'b00;
      end
      if (a_done) dones++;
      prev_gnt = a_gnt;
      @(negedge clk);
      cyc++;
    end
    a_req = 2'b00;
    check("rr_dones", 32'(dones), 32'd3);
    check("rr_grant_count", 32'(g_log.size()), 32'd3);
    if (g_log.size() == 3) begin
      check("rr_grant0", 32'(g_log[0]), 32'd1);
      check("rr_grant1", 32'(g_log[1]), 32'd2);
      check("rr_grant2", 32'(g_log[2]), 32'd1);
    end
    check("rr_both_gnt", 32'(a_both), 32'd0);

    // abort: idle abort ignored, then abort in the 5th SHIFT_HI
    a_req = 2'b01;
    a_abort = 1'b1;
    @(negedge clk);
    check("idle_abort_ignored", 32'(a_gnt), 32'd1);
    a_abort = 1'b0;
    a_req = 2'b00;
    a_rl = 0; a_dc = 0;
    shi = 0; cyc = 0;
    while (shi < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (a_st == ST_SHIFT_HI) shi++;
    end
    check("abort_reach_hi5", 32'(shi), 32'd5);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_gnt", 32'(a_gnt), 32'd0);
    check("abort_sclk", 32'(a_sclk), 32'd0);
    check("abort_srstn", 32'(a_srstn), 32'd1);
    repeat (5) @(negedge clk);
    check("abort_no_load", 32'(a_rl), 32'd0);
    check("abort_no_done", 32'(a_dc), 32'd0);
    a_req = 2'b11;
    @(negedge clk);
    a_req = 2'b00;
    check("abort_ptr_kept", 32'(a_gnt), 32'd2);
    wait_a_done("abort_follow_timeout", cyc);
    check("abort_follow_cycles", 32'(cyc), 32'd25);

    // CLK_DIV=2: every timed phase lasts 3 cycles
    b_req = 2'b01;
    @(negedge clk);
    b_req = 2'b00;
    check("b_gnt", 32'(b_gnt), 32'd1);
    prev_st = b_st; prev_sc = b_sclk; prev_sr = b_srstn;
    run = 1; cyc = 1; n_runs = 0;
    while (!b_done && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (b_st == prev_st && b_sclk == prev_sc && b_srstn == prev_sr) begin
        run++;
      end else begin
        if (prev_st == ST_SHIFT_LO || prev_st == ST_SHIFT_HI || prev_st == ST_LOAD) begin
          check("b_phase_len", 32'(run), 32'd3);
          n_runs++;
        end
        prev_st = b_st; prev_sc = b_sclk; prev_sr = b_srstn;
        run = 1;
      end
    end
    check("b_done_cycles", 32'(cyc), 32'd65);
    check("b_phase_runs", 32'(n_runs), 32'd20);

    // Defaults: 38x13, CLK_DIV=0
    c_edges = 0;
    c_req = 2'b01;
    @(negedge clk);
    c_req = 2'b00;
    check("c_gnt", 32'(c_gnt), 32'd1);
    cyc = 1; lows = 0;
    while (!c_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!c_srstn) lows++;
    end
    check("c_done_cycles", 32'(cyc), 32'd1069);
    check("c_shift_edges", 32'(c_edges), 32'd494);
    check("c_load_low_cycles", 32'(lows), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
